pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Program-counter stage of the 8-bit microprocessor. It consumes the 8-bit target selected by the `mux1` operand/branch mux and holds the current instruction address. It supports increment, jump, call and return through a small internal return-address stack. Its `PC` output drives instruction-memory addressing and feeds back as the sequential-address input of the mux.

## Interface
Parameters:
- `WIDTH`, 8: address width in bits.
- `DEPTH`, 4: return-stack entries; must be a power of two, at least 2.
- `RESET_PC`, 8'h00: PC value after reset.

Ports:
- `Clk`  input  1  sole clock; all state updates on the rising edge.
- `Reset_n`  input  1  asynchronous, active-low reset.
- `En`  input  1  advance enable; 0 = stall, all state held.
- `Op`  input  2  operation: 00 INC, 01 JUMP, 10 CALL, 11 RET.
- `Target`  input  WIDTH  jump/call destination, driven by the mux1 `Result`.
- `ClrErr`  input  1  synchronous clear of the sticky error flags.
- `PC`  output  WIDTH  current instruction address (registered).
- `Depth`  output  log2(DEPTH)+1  number of valid stack entries (registered).
- `Full`  output  1  Depth == DEPTH (combinational from Depth).
- `Empty`  output  1  Depth == 0 (combinational from Depth).
- `Overflow`  output  1  sticky: a CALL was issued while Full.
- `Underflow`  output  1  sticky: a RET was issued while Empty.

## Operation
- Reset (`Reset_n` = 0, asynchronous) forces:
  - `PC` = RESET_PC, `Depth` = 0, `Overflow` = 0, `Underflow` = 0.
  - `Empty` = 1, `Full` = 0.
  - Stack contents are don't-care and are never observable.
- `En` = 0: PC, stack, Depth and flags are held. `ClrErr` is still honoured.
- `En` = 1, per `Op`:
  - INC: PC <= PC + 1 modulo 2^WIDTH; 8'hFF wraps to 8'h00.
  - JUMP: PC <= Target.
  - CALL, not Full: push PC + 1 (mod 2^WIDTH) at index Depth; Depth += 1; PC <= Target.
  - CALL, Full: no push, Depth unchanged, PC <= PC + 1, Overflow <= 1.
  - RET, not Empty: PC <= entry[Depth-1]; Depth -= 1.
  - RET, Empty: Depth unchanged, PC <= PC + 1, Underflow <= 1.
- Stack behaviour: LIFO, implemented as a register array indexed by Depth. No circular overwrite; the oldest entry is never lost.
- `ClrErr` = 1 clears both sticky flags on the edge. If an error condition occurs on the same edge, the flag is set (set wins over clear).
- Internal control states:
  - RUN: normal operation.
  - ERR: either flag set; PC sequencing is identical to RUN, only the flags differ.
  - ERR -> RUN on ClrErr with no new error on that edge.

## Timing
- All outputs are registered except `Full` and `Empty`, which decode registered `Depth`.
- Latency: `Op` and `Target` are sampled on edge N; the new `PC` is visible after edge N. Single-cycle throughput, no stall cycles for any op.
- `Target` must be stable for setup before the edge. The mux1 path is combinational from `PC`, so PC -> mux1 -> `Target` is one register-to-register path.
- Back-to-back CALL/RET is legal every cycle. A RET immediately after a CALL returns the address pushed one edge earlier.
- Reset asserted mid-operation takes effect immediately, not on the next edge. Deassertion is synchronised externally, and the first edge after deassertion performs a normal op.

## Test plan
- Reset then 3 cycles of INC with En=1 -> PC 00, 01, 02, 03; Depth=0; Empty=1; flags 0.
- JUMP Target=8'hFE, then INC, INC -> PC FE, FF, 00 (wrap); no flags set.
- From PC=10: CALL 40, CALL 80, RET, RET -> PC 40, 80, 41, 11; Depth 1, 2, 1, 0.
- With DEPTH=4, five CALLs to 20 starting at PC=00:
  - After four CALLs: Full=1, Depth=4.
  - Fifth CALL: PC 20 -> 21, Overflow=1, Depth stays 4.
  - Four RETs then pop 21, 21, 21, 01.
- RET while Empty at PC=05 -> PC=06, Underflow=1. ClrErr together with a second empty RET -> Underflow stays 1. ClrErr alone -> Underflow=0.
- Stall and reset:
  - En=0 for 3 cycles with Op=JUMP -> PC and Depth unchanged.
  - Reset_n pulsed low between edges mid-sequence -> PC=00, Depth=0 immediately, before the next edge.

Source files
------------

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with return-address stack
//
// Purpose: holds the current instruction address. Each enabled edge applies one
// operation: increment, jump, call (push return address) or return (pop it).
// Call and return errors set sticky flags that stay set until ClrErr.
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   En         in   advance enable (0 = hold all state except flag clear)
//   Op         in   2-bit op: 00 INC, 01 JUMP, 10 CALL, 11 RET
//   Target     in   jump/call destination
//   ClrErr     in   synchronous clear of the sticky flags
//   PC         out  current instruction address (registered)
//   Depth      out  number of valid stack entries (registered)
//   Full/Empty out  decode of Depth
//   Overflow   out  sticky: CALL issued while Full
//   Underflow  out  sticky: RET issued while Empty

module pc_stack_unit #(
    parameter int                WIDTH    = 8,
    parameter int                DEPTH    = 4,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       En,
    input  logic [1:0]                 Op,
    input  logic [WIDTH-1:0]           Target,
    input  logic                       ClrErr,
    output logic [WIDTH-1:0]           PC,
    output logic [$clog2(DEPTH):0]     Depth,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_JUMP = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_t;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_pc;
    logic [DW-1:0]      r_depth;
    logic               r_overflow;
    logic               r_underflow;
    logic [WIDTH-1:0]   r_stack [DEPTH];

    logic [WIDTH-1:0]   w_pc_inc;
    logic               w_full;
    logic               w_empty;
    logic               w_is_call;
    logic               w_is_ret;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_evt;
    logic               w_unf_evt;
    logic               w_clear;
    logic               w_ovf_next;
    logic               w_unf_next;
    logic [AW-1:0]      w_push_idx;
    logic [AW-1:0]      w_top_idx;

    assign w_pc_inc   = r_pc + WIDTH'(1);
    assign w_full     = (r_depth == DW'(DEPTH));
    assign w_empty    = (r_depth == '0);
    assign w_is_call  = En && (op_t'(Op) == OP_CALL);
    assign w_is_ret   = En && (op_t'(Op) == OP_RET);
    assign w_push     = w_is_call && !w_full;
    assign w_pop      = w_is_ret  && !w_empty;
    assign w_ovf_evt  = w_is_call && w_full;
    assign w_unf_evt  = w_is_ret  && w_empty;

    // Low bits of Depth address the array; when Full they wrap to 0, so the
    // top-of-stack index (Depth-1) still lands on DEPTH-1.
    assign w_push_idx = r_depth[AW-1:0];
    assign w_top_idx  = r_depth[AW-1:0] - AW'(1);

    // Flags can only be nonzero in ERR, so the clear is gated on that state.
    // A new error on the same edge overrides the clear.
    assign w_clear    = (r_state == ST_ERR) && ClrErr;
    assign w_ovf_next = w_ovf_evt || (r_overflow  && !w_clear);
    assign w_unf_next = w_unf_evt || (r_underflow && !w_clear);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_next;
            r_underflow <= w_unf_next;
            r_state     <= (w_ovf_next || w_unf_next) ? ST_ERR : ST_RUN;

            if (En) begin
                case (op_t'(Op))
                    OP_INC:  r_pc <= w_pc_inc;
                    OP_JUMP: r_pc <= Target;
                    OP_CALL: begin
                        if (w_push) begin
                            r_pc    <= Target;
                            r_depth <= r_depth + DW'(1);
                        end else begin
                            r_pc    <= w_pc_inc;
                        end
                    end
                    OP_RET: begin
                        if (w_pop) begin
                            r_pc    <= r_stack[w_top_idx];
                            r_depth <= r_depth - DW'(1);
                        end else begin
                            r_pc    <= w_pc_inc;
                        end
                    end
                    default: r_pc <= w_pc_inc;
                endcase
            end
        end
    end

    // Stack contents are never observable after reset, so they carry no reset.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign PC        = r_pc;
    assign Depth     = r_depth;
    assign Full      = w_full;
    assign Empty     = w_empty;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - self-checking bench for pc_stack_unit

module tb_pc_stack_unit;

    localparam int W  = 8;
    localparam int D  = 4;

    logic         Clk;
    logic         Reset_n;
    logic         En;
    logic [1:0]   Op;
    logic [W-1:0] Target;
    logic         ClrErr;
    logic [W-1:0] PC;
    logic [2:0]   Depth;
    logic         Full;
    logic         Empty;
    logic         Overflow;
    logic         Underflow;

    int errs   = 0;
    int checks = 0;
    bit chk_on = 0;

    pc_stack_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(8'h00)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .En        (En),
        .Op        (Op),
        .Target    (Target),
        .ClrErr    (ClrErr),
        .PC        (PC),
        .Depth     (Depth),
        .Full      (Full),
        .Empty     (Empty),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: plain integer PC and a return-address list.
    int m_pc;
    int m_depth;
    bit m_ovf;
    bit m_unf;
    int m_stk [0:D-1];

    int nm_pc;
    int nm_depth;
    bit nm_ovf;
    bit nm_unf;
    bit nm_push;

    always_comb begin
        nm_pc    = m_pc;
        nm_depth = m_depth;
        nm_ovf   = m_ovf && !ClrErr;
        nm_unf   = m_unf && !ClrErr;
        nm_push  = 1'b0;
        if (En) begin
            case (Op)
                2'd0: nm_pc = (m_pc + 1) % 256;
                2'd1: nm_pc = int'(Target);
                2'd2: begin
                    if (m_depth == D) begin
                        nm_pc  = (m_pc + 1) % 256;
                        nm_ovf = 1'b1;
                    end else begin
                        nm_push  = 1'b1;
                        nm_depth = m_depth + 1;
                        nm_pc    = int'(Target);
                    end
                end
                default: begin
                    if (m_depth == 0) begin
                        nm_pc  = (m_pc + 1) % 256;
                        nm_unf = 1'b1;
                    end else begin
                        nm_pc    = m_stk[m_depth-1];
                        nm_depth = m_depth - 1;
                    end
                end
            endcase
        end
    end

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pc    <= 0;
            m_depth <= 0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
        end else begin
            if (nm_push) m_stk[m_depth] <= (m_pc + 1) % 256;
            m_pc    <= nm_pc;
            m_depth <= nm_depth;
            m_ovf   <= nm_ovf;
            m_unf   <= nm_unf;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process against the model, away from the rising edge.
    always @(negedge Clk) begin
        if (chk_on && Reset_n) begin
            chk("model_pc",    int'(PC),        m_pc);
            chk("model_depth", int'(Depth),     m_depth);
            chk("model_full",  int'(Full),      int'(m_depth == D));
            chk("model_empty", int'(Empty),     int'(m_depth == 0));
            chk("model_ovf",   int'(Overflow),  int'(m_ovf));
            chk("model_unf",   int'(Underflow), int'(m_unf));
        end
    end

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input bit en, input logic [1:0] op, input logic [7:0] tgt, input bit clr);
        En     = en;
        Op     = op;
        Target = tgt;
        ClrErr = clr;
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    task automatic reset_pulse();
        Reset_n = 1'b0;
        #1;
        chk("rst_async_pc",    int'(PC),    0);
        chk("rst_async_depth", int'(Depth), 0);
        chk("rst_async_empty", int'(Empty), 1);
        chk("rst_async_flags", int'({Overflow, Underflow}), 0);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0;
        En      = 1'b0;
        Op      = 2'd0;
        Target  = '0;
        ClrErr  = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        #1;
        chk("reset_pc",    int'(PC),    0);
        chk("reset_depth", int'(Depth), 0);
        chk("reset_empty", int'(Empty), 1);
        chk("reset_full",  int'(Full),  0);
        chk("reset_flags", int'({Overflow, Underflow}), 0);
        Reset_n = 1'b1;
        chk_on  = 1'b1;

        // Increment from reset
        step(1, 2'd0, 8'h00, 0); chk("inc1", int'(PC), 8'h01);
        step(1, 2'd0, 8'h00, 0); chk("inc2", int'(PC), 8'h02);
        step(1, 2'd0, 8'h00, 0); chk("inc3", int'(PC), 8'h03);

        // Jump and wrap
        step(1, 2'd1, 8'hFE, 0); chk("jump_fe", int'(PC), 8'hFE);
        step(1, 2'd0, 8'h00, 0); chk("inc_ff",  int'(PC), 8'hFF);
        step(1, 2'd0, 8'h00, 0); chk("wrap_00", int'(PC), 8'h00);
        chk("wrap_flags", int'({Overflow, Underflow}), 0);

        // Nested call/return
        step(1, 2'd1, 8'h10, 0);
        step(1, 2'd2, 8'h40, 0); chk("call40_pc", int'(PC), 8'h40); chk("call40_d", int'(Depth), 1);
        step(1, 2'd2, 8'h80, 0); chk("call80_pc", int'(PC), 8'h80); chk("call80_d", int'(Depth), 2);
        step(1, 2'd3, 8'h00, 0); chk("ret1_pc",   int'(PC), 8'h41); chk("ret1_d",   int'(Depth), 1);
        step(1, 2'd3, 8'h00, 0); chk("ret2_pc",   int'(PC), 8'h11); chk("ret2_d",   int'(Depth), 0);

        // Fill, overflow, drain
        step(1, 2'd1, 8'h00, 0);
        repeat (4) step(1, 2'd2, 8'h20, 0);
        chk("fill_full", int'(Full), 1);
        chk("fill_depth", int'(Depth), 4);
        step(1, 2'd2, 8'h20, 0);
        chk("ovf_pc", int'(PC), 8'h21);
        chk("ovf_flag", int'(Overflow), 1);
        chk("ovf_depth", int'(Depth), 4);
        step(1, 2'd3, 8'h00, 0); chk("pop1", int'(PC), 8'h21);
        step(1, 2'd3, 8'h00, 0); chk("pop2", int'(PC), 8'h21);
        step(1, 2'd3, 8'h00, 0); chk("pop3", int'(PC), 8'h21);
        step(1, 2'd3, 8'h00, 0); chk("pop4", int'(PC), 8'h01);
        chk("drain_empty", int'(Empty), 1);
        step(0, 2'd0, 8'h00, 1); chk("ovf_clr", int'(Overflow), 0);

        // Underflow, set-wins-over-clear, clear alone
        step(1, 2'd1, 8'h05, 0);
        step(1, 2'd3, 8'h00, 0); chk("unf_pc", int'(PC), 8'h06); chk("unf_flag", int'(Underflow), 1);
        step(1, 2'd3, 8'h00, 1); chk("unf_set_wins", int'(Underflow), 1); chk("unf_pc2", int'(PC), 8'h07);
        step(0, 2'd0, 8'h00, 1); chk("unf_clr", int'(Underflow), 0); chk("unf_clr_pc", int'(PC), 8'h07);

        // Stall
        step(1, 2'd2, 8'h30, 0);
        repeat (3) step(0, 2'd1, 8'hAA, 0);
        chk("stall_pc", int'(PC), 8'h30);
        chk("stall_depth", int'(Depth), 1);

        // Asynchronous reset between edges, then a normal first op
        reset_pulse();
        step(1, 2'd0, 8'h00, 0); chk("post_rst_inc", int'(PC), 8'h01);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) reset_pulse();
            step(($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
